// File: rtl/lstm_accel_mmio_if.sv
// Bus and stream bundle for the LSTM/FC accelerator MMIO front-end.
//   device_*   : Ibex device-bus slave port (request in, registered response out)
//   core_in_*  : operand stream towards the compute core
//   core_out_* : result stream coming back from the compute core
// Handshake rule for both core streams: a word moves on a rising clk edge
// where valid and ready are both high; valid never waits on ready.
// Modport slave is the accelerator's view, master is the environment's view.
interface lstm_accel_mmio_if #(
    parameter int DataWidth = 32
);
    logic                 device_req_i;
    logic [31:0]          device_addr_i;
    logic                 device_we_i;
    logic [3:0]           device_be_i;
    logic [31:0]          device_wdata_i;
    logic                 device_rvalid_o;
    logic [31:0]          device_rdata_o;

    logic                 core_in_valid_o;
    logic [DataWidth-1:0] core_in_data_o;
    logic                 core_in_last_o;
    logic                 core_in_ready_i;

    logic                 core_out_valid_i;
    logic [DataWidth-1:0] core_out_data_i;
    logic                 core_out_ready_o;

    modport slave (
        input  device_req_i, device_addr_i, device_we_i, device_be_i, device_wdata_i,
        output device_rvalid_o, device_rdata_o,
        output core_in_valid_o, core_in_data_o, core_in_last_o,
        input  core_in_ready_i,
        input  core_out_valid_i, core_out_data_i,
        output core_out_ready_o
    );

    modport master (
        output device_req_i, device_addr_i, device_we_i, device_be_i, device_wdata_i,
        input  device_rvalid_o, device_rdata_o,
        input  core_in_valid_o, core_in_data_o, core_in_last_o,
        output core_in_ready_i,
        output core_out_valid_i, core_out_data_i,
        input  core_out_ready_o
    );
endinterface

// File: rtl/lstm_accel_mmio.sv
// MMIO front-end for the LSTM/FC accelerator core.
// Software pushes operand words into an input FIFO, starts an operation,
// and the sequencer streams the operands to the core until the word tagged
// "last" is consumed; it then counts OutWords results into the output FIFO,
// sets the sticky done flag and returns to idle.
// Ports:
//   clk, rst     clock and synchronous active-high reset
//   bus          lstm_accel_mmio_if.slave (device bus + core streams)
//   irq_o        done & irq_en
//   dbg_state_o  current sequencer state (0 idle, 1 stream, 2 collect, 3 done)
module lstm_accel_mmio #(
    parameter logic [31:0] BaseAddr  = 32'h8000_5000,
    parameter int          DataWidth = 32,
    parameter int          InDepth   = 8,
    parameter int          OutDepth  = 8,
    parameter int          OutWords  = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    lstm_accel_mmio_if.slave        bus,
    output logic                    irq_o,
    output logic [1:0]              dbg_state_o
);
    localparam int InAw  = $clog2(InDepth);
    localparam int OutAw = $clog2(OutDepth);
    localparam logic [7:0] OutWordsW = 8'(OutWords);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_STREAM  = 2'd1,
        S_COLLECT = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    state_t state_q, state_d;

    // ---------------- register decode ----------------
    logic [31:0] off;
    logic        wr, rd;
    logic        start_p, clr_p, irq_clr_p;
    logic        bus_push, bus_push_last, out_pop_req;
    logic [31:0] wdata_masked;

    assign off       = bus.device_addr_i - BaseAddr;
    assign wr        = bus.device_req_i & bus.device_we_i;
    assign rd        = bus.device_req_i & ~bus.device_we_i;
    assign start_p   = wr && (off == 32'h00) && bus.device_wdata_i[0];
    assign clr_p     = wr && (off == 32'h00) && bus.device_wdata_i[1];
    assign irq_clr_p = wr && (off == 32'h14);
    assign bus_push      = wr && ((off == 32'h08) || (off == 32'h0C));
    assign bus_push_last = (off == 32'h0C);
    assign out_pop_req   = rd && (off == 32'h10);

    always_comb begin
        for (int b = 0; b < 4; b++) begin
            wdata_masked[8*b +: 8] = bus.device_be_i[b] ? bus.device_wdata_i[8*b +: 8] : 8'h00;
        end
    end

    // ---------------- input FIFO ({last, data}) ----------------
    logic [DataWidth:0] in_mem [InDepth];
    logic [InAw-1:0]    in_wptr, in_rptr;
    logic [InAw:0]      in_count;
    logic               in_full, in_empty, in_push, in_pop;

    assign in_full  = (in_count == (InAw+1)'(InDepth));
    assign in_empty = (in_count == '0);
    // Full is judged before any same-cycle pop, so a push into a full FIFO is always lost.
    assign in_push  = bus_push & ~in_full;

    always_ff @(posedge clk) begin
        if (in_push) begin
            in_mem[in_wptr] <= {bus_push_last, wdata_masked[DataWidth-1:0]};
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clr_p) begin
            in_wptr  <= '0;
            in_rptr  <= '0;
            in_count <= '0;
        end else begin
            if (in_push) in_wptr <= in_wptr + 1'b1;
            if (in_pop)  in_rptr <= in_rptr + 1'b1;
            case ({in_push, in_pop})
                2'b10:   in_count <= in_count + 1'b1;
                2'b01:   in_count <= in_count - 1'b1;
                default: in_count <= in_count;
            endcase
        end
    end

    // ---------------- output FIFO ----------------
    logic [DataWidth-1:0] out_mem [OutDepth];
    logic [OutAw-1:0]     out_wptr, out_rptr;
    logic [OutAw:0]       out_count;
    logic                 out_full, out_empty, out_push, out_pop;

    assign out_full  = (out_count == (OutAw+1)'(OutDepth));
    assign out_empty = (out_count == '0);
    assign out_push  = bus.core_out_valid_i & ~out_full;
    assign out_pop   = out_pop_req & ~out_empty;

    always_ff @(posedge clk) begin
        if (out_push) begin
            out_mem[out_wptr] <= bus.core_out_data_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clr_p) begin
            out_wptr  <= '0;
            out_rptr  <= '0;
            out_count <= '0;
        end else begin
            if (out_push) out_wptr <= out_wptr + 1'b1;
            if (out_pop)  out_rptr <= out_rptr + 1'b1;
            case ({out_push, out_pop})
                2'b10:   out_count <= out_count + 1'b1;
                2'b01:   out_count <= out_count - 1'b1;
                default: out_count <= out_count;
            endcase
        end
    end

    // ---------------- sequencer ----------------
    logic [7:0] res_count;
    logic       res_inc;
    logic       in_valid;

    always_ff @(posedge clk) begin
        if (rst || clr_p) state_q <= S_IDLE;
        else              state_q <= state_d;
    end

    always_comb begin
        state_d  = state_q;
        in_valid = 1'b0;
        in_pop   = 1'b0;
        res_inc  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start_p) state_d = S_STREAM;
            end
            S_STREAM: begin
                in_valid = ~in_empty;
                if (in_valid && bus.core_in_ready_i) begin
                    in_pop = 1'b1;
                    if (in_mem[in_rptr][DataWidth]) state_d = S_COLLECT;
                end
            end
            S_COLLECT: begin
                if (out_push) begin
                    res_inc = 1'b1;
                    if (res_count + 8'd1 == OutWordsW) state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign bus.core_in_valid_o  = in_valid;
    assign bus.core_in_data_o   = in_mem[in_rptr][DataWidth-1:0];
    assign bus.core_in_last_o   = in_valid & in_mem[in_rptr][DataWidth];
    assign bus.core_out_ready_o = ~out_full;
    assign dbg_state_o          = state_q;

    // ---------------- control / status flags ----------------
    logic irq_en, done, ovf, unf;

    always_ff @(posedge clk) begin
        if (rst) begin
            irq_en <= 1'b0;
        end else if (wr && (off == 32'h00)) begin
            irq_en <= bus.device_wdata_i[2];
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clr_p) begin
            done      <= 1'b0;
            ovf       <= 1'b0;
            unf       <= 1'b0;
            res_count <= '0;
        end else begin
            // Entering DONE outranks a same-cycle IRQ_CLR so completion is never lost.
            if (state_q == S_DONE)                    done <= 1'b1;
            else if (irq_clr_p)                       done <= 1'b0;
            else if (state_q == S_IDLE && start_p)    done <= 1'b0;

            if (bus_push && in_full)           ovf <= 1'b1;
            if (out_pop_req && out_empty)      unf <= 1'b1;

            if (state_q == S_IDLE && start_p)  res_count <= '0;
            else if (res_inc)                  res_count <= res_count + 8'd1;
        end
    end

    assign irq_o = done & irq_en;

    // ---------------- read mux and response ----------------
    logic [31:0] rdata_d;

    always_comb begin
        rdata_d = '0;
        if (rd) begin
            case (off)
                32'h00: rdata_d = {29'b0, irq_en, 2'b00};
                32'h04: rdata_d = {res_count, 8'(out_count), 8'(in_count),
                                   1'b0, unf, ovf, out_empty, in_empty, in_full, done,
                                   (state_q != S_IDLE)};
                32'h10: rdata_d = out_empty ? 32'h0 : 32'(out_mem[out_rptr]);
                default: rdata_d = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bus.device_rvalid_o <= 1'b0;
            bus.device_rdata_o  <= '0;
        end else begin
            bus.device_rvalid_o <= bus.device_req_i;
            bus.device_rdata_o  <= rdata_d;
        end
    end
endmodule

// File: tb/tb_lstm_accel_mmio.sv
module tb_lstm_accel_mmio;
    localparam logic [31:0] BASE   = 32'h8000_5000;
    localparam logic [31:0] R_CTRL = BASE + 32'h00;
    localparam logic [31:0] R_STAT = BASE + 32'h04;
    localparam logic [31:0] R_DIN  = BASE + 32'h08;
    localparam logic [31:0] R_DLST = BASE + 32'h0C;
    localparam logic [31:0] R_DOUT = BASE + 32'h10;
    localparam logic [31:0] R_ICLR = BASE + 32'h14;

    logic       clk;
    logic       rst;
    logic       irq;
    logic [1:0] dbg_state;

    lstm_accel_mmio_if #(.DataWidth(32)) bus ();

    lstm_accel_mmio #(
        .BaseAddr(BASE), .DataWidth(32), .InDepth(8), .OutDepth(8), .OutWords(8)
    ) dut (
        .clk(clk), .rst(rst), .bus(bus), .irq_o(irq), .dbg_state_o(dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [32:0] exp_q[$];
    logic [32:0] got_q[$];
    logic [31:0] out_exp_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // operand beats seen on the core input stream
    always @(negedge clk) begin
        if (!rst && bus.core_in_valid_o && bus.core_in_ready_i)
            got_q.push_back({bus.core_in_last_o, bus.core_in_data_o});
    end

    // driver tasks
    task automatic bus_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] be);
        @(negedge clk);
        bus.device_req_i = 1'b1; bus.device_we_i = 1'b1;
        bus.device_addr_i = addr; bus.device_wdata_i = data; bus.device_be_i = be;
        @(negedge clk);
        bus.device_req_i = 1'b0; bus.device_we_i = 1'b0;
    endtask

    task automatic bus_read(input logic [31:0] addr, output logic [31:0] data);
        @(negedge clk);
        bus.device_req_i = 1'b1; bus.device_we_i = 1'b0;
        bus.device_addr_i = addr; bus.device_be_i = 4'hF;
        @(negedge clk);
        bus.device_req_i = 1'b0;
        data = bus.device_rdata_o;
        check("rvalid", {31'b0, bus.device_rvalid_o}, 32'd1);
    endtask

    task automatic read_check(input string tag, input logic [31:0] addr, input logic [31:0] exp);
        logic [31:0] d;
        bus_read(addr, d);
        check(tag, d, exp);
    endtask

    task automatic push(input logic [31:0] data, input logic last);
        bus_write(last ? R_DLST : R_DIN, data, 4'hF);
        exp_q.push_back({last, data});
    endtask

    task automatic wait_beats(input int n);
        int cyc = 0;
        while (got_q.size() < n && cyc < 60) begin
            @(negedge clk);
            cyc++;
        end
        check("beat_count", got_q.size(), n);
    endtask

    task automatic compare_beats(input int n);
        logic [32:0] g, e;
        for (int i = 0; i < n; i++) begin
            if (got_q.size() == 0 || exp_q.size() == 0) begin
                check("beat_missing", 32'd0, 32'd1);
                return;
            end
            g = got_q.pop_front();
            e = exp_q.pop_front();
            check("beat_data", g[31:0], e[31:0]);
            check("beat_last", {31'b0, g[32]}, {31'b0, e[32]});
        end
    endtask

    initial begin
        logic [31:0] d;
        rst = 1'b1;
        bus.device_req_i = 1'b0; bus.device_we_i = 1'b0; bus.device_addr_i = '0;
        bus.device_be_i = 4'h0; bus.device_wdata_i = '0;
        bus.core_in_ready_i = 1'b0; bus.core_out_valid_i = 1'b0; bus.core_out_data_i = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // reset state
        check("rst_rvalid",  {31'b0, bus.device_rvalid_o}, 32'd0);
        check("rst_rdata",   bus.device_rdata_o, 32'd0);
        check("rst_in_valid", {31'b0, bus.core_in_valid_o}, 32'd0);
        check("rst_in_last", {31'b0, bus.core_in_last_o}, 32'd0);
        check("rst_out_ready", {31'b0, bus.core_out_ready_o}, 32'd1);
        check("rst_irq",     {31'b0, irq}, 32'd0);
        read_check("rst_ctrl", R_CTRL, 32'h0);
        read_check("rst_status", R_STAT, 32'h0000_0018);

        // 1: three operands plus a last, then start with the core ready
        push(32'h11, 1'b0); push(32'h22, 1'b0); push(32'h33, 1'b0); push(32'hA5, 1'b1);
        read_check("status_4", R_STAT, 32'h0000_0410);
        bus.core_in_ready_i = 1'b1;
        bus_write(R_CTRL, 32'h5, 4'hF);
        wait_beats(4);
        compare_beats(4);
        repeat (2) @(negedge clk);
        check("state_collect", {30'b0, dbg_state}, 32'd2);
        read_check("status_collect", R_STAT, 32'h0000_0019);

        // 2: eight results, irq, ordered readback, irq clear
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            bus.core_out_valid_i = 1'b1;
            bus.core_out_data_i = 32'h100 + 32'(i) * 32'h11;
            out_exp_q.push_back(32'h100 + 32'(i) * 32'h11);
        end
        @(negedge clk);
        bus.core_out_valid_i = 1'b0;
        repeat (2) @(negedge clk);
        check("state_idle", {30'b0, dbg_state}, 32'd0);
        check("irq_set", {31'b0, irq}, 32'd1);
        read_check("status_done", R_STAT, 32'h0808_000A);
        for (int i = 0; i < 8; i++) begin
            read_check("data_out", R_DOUT, out_exp_q.pop_front());
        end
        bus_write(R_ICLR, 32'h0, 4'hF);
        @(negedge clk);
        check("irq_clr", {31'b0, irq}, 32'd0);

        // 4: pop of empty output FIFO
        read_check("empty_pop", R_DOUT, 32'h0);
        read_check("status_unf", R_STAT, 32'h0800_0058);

        // 3: nine pushes into an 8-deep FIFO; ninth must vanish
        bus.core_in_ready_i = 1'b0;
        for (int i = 0; i < 9; i++) begin
            bus_write(R_DIN, 32'h200 + 32'(i), 4'hF);
            if (i < 8) exp_q.push_back({1'b0, 32'h200 + 32'(i)});
        end
        read_check("status_ovf", R_STAT, 32'h0800_0874);
        bus.core_in_ready_i = 1'b1;
        bus_write(R_CTRL, 32'h5, 4'hF);
        wait_beats(8);
        repeat (10) @(negedge clk);
        check("no_ninth", got_q.size(), 32'd8);
        compare_beats(8);
        check("state_stream", {30'b0, dbg_state}, 32'd1);

        // 6a: soft_clear mid-STREAM keeps irq_en
        bus.core_in_ready_i = 1'b0;
        bus_write(R_DIN, 32'h300, 4'hF);
        bus_write(R_DIN, 32'h301, 4'hF);
        bus_write(R_CTRL, 32'h6, 4'hF);
        check("clr_state", {30'b0, dbg_state}, 32'd0);
        check("clr_in_valid", {31'b0, bus.core_in_valid_o}, 32'd0);
        read_check("clr_status", R_STAT, 32'h0000_0018);
        read_check("clr_ctrl", R_CTRL, 32'h0000_0004);

        // 5: byte enables mask the pushed word
        bus_write(R_DLST, 32'hDEAD_BEEF, 4'b0011);
        exp_q.push_back({1'b1, 32'h0000_BEEF});
        bus.core_in_ready_i = 1'b1;
        bus_write(R_CTRL, 32'h5, 4'hF);
        wait_beats(1);
        compare_beats(1);

        // 6b: rst mid-STREAM clears irq_en too
        bus_write(R_CTRL, 32'h6, 4'hF);
        bus.core_in_ready_i = 1'b0;
        bus_write(R_DIN, 32'h55, 4'hF);
        bus_write(R_CTRL, 32'h5, 4'hF);
        check("pre_rst_state", {30'b0, dbg_state}, 32'd1);
        check("pre_rst_valid", {31'b0, bus.core_in_valid_o}, 32'd1);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst2_state", {30'b0, dbg_state}, 32'd0);
        check("rst2_in_valid", {31'b0, bus.core_in_valid_o}, 32'd0);
        read_check("rst2_ctrl", R_CTRL, 32'h0);
        read_check("rst2_status", R_STAT, 32'h0000_0018);
        check("rst2_got_empty", got_q.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=%0d exp=0", total);
        $fatal(1, "timeout");
    end
endmodule
